// File: rtl/dmem_arbiter.sv
// Two-requester arbiter sharing a single-port synchronous data memory.
// Each access runs IDLE -> ISSUE -> RESP (3 cycles, no overlap); round-robin or fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RR_ENABLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              stall0,
  output logic              stall1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              state_q;
  logic                prio_q;
  logic                gnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                win_d;
  logic                resp_act;

  always_comb begin
    win_d = req1;
    if (req0 && req1) begin
      win_d = (RR_ENABLE != 0) ? prio_q : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            gnt_q   <= win_d;
            we_q    <= win_d ? we1 : we0;
            addr_q  <= win_d ? addr1 : addr0;
            wdata_q <= win_d ? wdata1 : wdata0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          we_q    <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          prio_q  <= ~gnt_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset masks the write strobe and acks in the same cycle, so a reset landing
  // on ISSUE keeps the memory from committing the aborted write.
  assign resp_act  = (state_q == RESP) && !reset;
  assign ack0      = resp_act && !gnt_q;
  assign ack1      = resp_act && gnt_q;
  assign rdata0    = ack0 ? mem_rdata : '0;
  assign rdata1    = ack1 ? mem_rdata : '0;
  assign stall0    = req0 && !ack0;
  assign stall1    = req1 && !ack1;
  assign mem_we    = we_q && !reset;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin and one fixed-priority instance share stimulus,
// each with its own memory and a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_mem = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic [31:0] rdata0_w [2];
  logic [31:0] rdata1_w [2];
  logic        ack0_w [2];
  logic        ack1_w [2];
  logic        stall0_w [2];
  logic        stall1_w [2];
  logic [31:0] mem_addr_w [2];
  logic        mem_we_w [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] mem_rdata_w [2];
  logic        busy_w [2];
  logic        gnt_w [2];

  logic [31:0] mem [2][256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_ENABLE(1)) u_rr (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0_w[0]), .rdata1(rdata1_w[0]), .ack0(ack0_w[0]), .ack1(ack1_w[0]),
    .stall0(stall0_w[0]), .stall1(stall1_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_we(mem_we_w[0]), .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]),
    .busy(busy_w[0]), .gnt_id(gnt_w[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_ENABLE(0)) u_fp (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .rdata0(rdata0_w[1]), .rdata1(rdata1_w[1]), .ack0(ack0_w[1]), .ack1(ack1_w[1]),
    .stall0(stall0_w[1]), .stall1(stall1_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_we(mem_we_w[1]), .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]),
    .busy(busy_w[1]), .gnt_id(gnt_w[1])
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 64) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(i);
  endfunction

  // Word-indexed synchronous memories, one-cycle read latency
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (init_mem) begin
        for (int i = 0; i < 256; i++) mem[k][i] <= init_val(i);
      end else begin
        if (mem_we_w[k]) mem[k][mem_addr_w[k][9:2]] <= mem_wdata_w[k];
        mem_rdata_w[k] <= mem[k][mem_addr_w[k][9:2]];
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s[inst%0d] at %0t: got %h expected %h", nm, k, $time, act_v, exp_v);
    end
  endtask

  // Reference model: a transaction granted at idle cycle s drives memory in s+1 and acks in s+2
  int          cyc = 0;
  bit          m_act [2];
  int          m_start [2];
  bit          m_own [2];
  bit          m_ptr [2];
  bit          m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [31:0] shadow [2][256];

  task automatic model_step(input int k);
    logic e_ack0, e_ack1;
    int   ph;
    e_ack0 = 1'b0;
    e_ack1 = 1'b0;
    if (reset) begin
      m_act[k] = 1'b0; m_ptr[k] = 1'b0; m_own[k] = 1'b0;
      m_we[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
      chk("rst_ack0", k, 32'(ack0_w[k]), 0);
      chk("rst_ack1", k, 32'(ack1_w[k]), 0);
      chk("rst_rdata0", k, rdata0_w[k], 0);
      chk("rst_rdata1", k, rdata1_w[k], 0);
      chk("rst_mem_we", k, 32'(mem_we_w[k]), 0);
    end else begin
      chk("mem_addr", k, mem_addr_w[k], m_addr[k]);
      chk("mem_wdata", k, mem_wdata_w[k], m_wd[k]);
      chk("gnt_id", k, 32'(gnt_w[k]), 32'(m_own[k]));
      chk("busy", k, 32'(busy_w[k]), 32'(m_act[k]));
      ph = cyc - m_start[k];
      if (m_act[k] && ph == 1) begin
        chk("mem_we_issue", k, 32'(mem_we_w[k]), 32'(m_we[k]));
        if (m_we[k]) shadow[k][m_addr[k][9:2]] = m_wd[k];
      end else begin
        chk("mem_we_off", k, 32'(mem_we_w[k]), 0);
      end
      if (m_act[k] && ph == 2) begin
        e_ack0 = !m_own[k];
        e_ack1 = m_own[k];
        if (!m_we[k]) begin
          if (m_own[k]) chk("rdata1", k, rdata1_w[k], shadow[k][m_addr[k][9:2]]);
          else          chk("rdata0", k, rdata0_w[k], shadow[k][m_addr[k][9:2]]);
        end
        if (m_own[k]) chk("rdata0_idle", k, rdata0_w[k], 0);
        else          chk("rdata1_idle", k, rdata1_w[k], 0);
        m_act[k] = 1'b0;
        m_ptr[k] = !m_own[k];
      end else if (!m_act[k]) begin
        chk("rdata0_idle", k, rdata0_w[k], 0);
        chk("rdata1_idle", k, rdata1_w[k], 0);
        if (req0 || req1) begin
          if (req0 && req1) m_own[k] = (k == 0) ? m_ptr[k] : 1'b0;
          else              m_own[k] = req1;
          m_we[k]    = m_own[k] ? we1 : we0;
          m_addr[k]  = m_own[k] ? addr1 : addr0;
          m_wd[k]    = m_own[k] ? wdata1 : wdata0;
          m_act[k]   = 1'b1;
          m_start[k] = cyc;
        end
      end
      chk("ack0", k, 32'(ack0_w[k]), 32'(e_ack0));
      chk("ack1", k, 32'(ack1_w[k]), 32'(e_ack1));
    end
    chk("stall0", k, 32'(stall0_w[k]), 32'(req0 && !(ack0_w[k] === 1'b1 && e_ack0)));
    chk("stall1", k, 32'(stall1_w[k]), 32'(req1 && !(ack1_w[k] === 1'b1 && e_ack1)));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_start[k] = 0; m_own[k] = 1'b0; m_ptr[k] = 1'b0;
      m_we[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
      for (int i = 0; i < 256; i++) shadow[k][i] = init_val(i);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) model_step(k);
      cyc++;
    end
  end

  task automatic drv;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Issue a lone read on requester 0 and check the ack cycle against a literal value
  task automatic read0(input logic [31:0] a, input logic [31:0] exp_v, input string nm);
    drv; req0 = 1'b1; we0 = 1'b0; addr0 = a;
    smp; drv; smp; drv; smp;
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_ack"}, k, 32'(ack0_w[k]), 1);
      chk(nm, k, rdata0_w[k], exp_v);
    end
    drv; req0 = 1'b0;
    smp;
  endtask

  initial begin
    drv; init_mem = 1'b0;
    drv; reset = 1'b0;
    smp;
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_busy", k, 32'(busy_w[k]), 0);
      chk("post_rst_addr", k, mem_addr_w[k], 0);
    end

    // Single read of 0x100
    drv; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    smp; chk("rd_stall_T", 0, 32'(stall0_w[0]), 1);
    drv; smp; chk("rd_issue_addr", 0, mem_addr_w[0], 32'h100);
    drv; smp;
    for (int k = 0; k < 2; k++) begin
      chk("rd_ack", k, 32'(ack0_w[k]), 1);
      chk("rd_data", k, rdata0_w[k], 32'hDEADBEEF);
      chk("rd_stall_ack", k, 32'(stall0_w[k]), 0);
    end
    drv; req0 = 1'b0;
    smp;

    // Single write to 0x40 then read back
    drv; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h12345678;
    smp; drv; smp;
    for (int k = 0; k < 2; k++) chk("wr_we_issue", k, 32'(mem_we_w[k]), 1);
    drv; smp;
    for (int k = 0; k < 2; k++) begin
      chk("wr_ack", k, 32'(ack1_w[k]), 1);
      chk("wr_we_resp", k, 32'(mem_we_w[k]), 0);
    end
    drv; req1 = 1'b0; we1 = 1'b0;
    smp;
    read0(32'h40, 32'h12345678, "wr_readback");

    // Request withdrawn during ISSUE
    drv; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h104;
    smp; drv; req0 = 1'b0;
    smp; drv; smp;
    for (int k = 0; k < 2; k++) chk("wd_ack", k, 32'(ack0_w[k]), 1);
    drv; smp; drv; smp;
    for (int k = 0; k < 2; k++) chk("wd_idle", k, 32'(busy_w[k]), 0);

    // Reset during ISSUE of a write
    drv; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80; wdata1 = 32'hAAAA5555;
    smp; drv; reset = 1'b1;
    smp;
    for (int k = 0; k < 2; k++) chk("rw_we_masked", k, 32'(mem_we_w[k]), 0);
    drv; reset = 1'b0; req1 = 1'b0; we1 = 1'b0;
    smp;
    for (int k = 0; k < 2; k++) begin
      chk("rw_busy", k, 32'(busy_w[k]), 0);
      chk("rw_addr", k, mem_addr_w[k], 0);
      chk("rw_wdata", k, mem_wdata_w[k], 0);
      chk("rw_ack1", k, 32'(ack1_w[k]), 0);
    end
    read0(32'h80, 32'hC0DE0020, "rw_mem_kept");

    // Continuous contention from reset
    drv; reset = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    addr0 = 32'h0C; addr1 = 32'h10;
    drv; reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      smp;
      chk("rr_ack0", 0, 32'(ack0_w[0]), 32'(c == 2 || c == 8));
      chk("rr_ack1", 0, 32'(ack1_w[0]), 32'(c == 5 || c == 11));
      chk("fp_ack0", 1, 32'(ack0_w[1]), 32'(c % 3 == 2));
      chk("fp_ack1", 1, 32'(ack1_w[1]), 0);
      drv;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drv;
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
        addr0 = 32'($urandom_range(0, 15)) << 2; wdata0 = $urandom;
      end
      if ($urandom_range(0, 3) == 0) begin
        req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
        addr1 = 32'($urandom_range(0, 15)) << 2; wdata1 = $urandom;
      end
    end
    drv; reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
    smp; smp;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
